// File: rtl/regfile_pkg.sv
// Shared constants for the scoreboarded register file.
package regfile_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_NUM_RD = 2;
   localparam int ZERO_IDX   = 0;

   // Jump-and-link always targets the highest register of the file.
   function automatic int link_index(input int addr_w);
      return (32'sd1 << addr_w) - 32'sd1;
   endfunction

   localparam int DEF_LINK_IDX = link_index(DEF_ADDR_W);

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Pending-load scoreboard and read-port stall detection for regfile_sb.
// Honours REGFILE_SB_BYPASS_EN: when defined, a register written this cycle does not stall.
module regfile_sb_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_RD = DEF_NUM_RD
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     sb_set_i,
   input  logic [ADDR_W-1:0]        sb_addr_i,
   input  logic                     wr_fire_i,
   input  logic [ADDR_W-1:0]        wr_idx_i,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
   output logic                     stall_o,
   output logic [(2**ADDR_W)-1:0]   pending_o
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0] pending_q;
   logic [DEPTH-1:0] pending_d;
   logic             stall_s;

   // Next pending vector: write-back clears, a newly issued load sets and wins.
   always_comb begin
      pending_d = pending_q;
      pending_d[wr_idx_i] = wr_fire_i ? 1'b0 : pending_q[wr_idx_i];
      pending_d[sb_addr_i] = (sb_set_i && (sb_addr_i != ADDR_W'(ZERO_IDX))) ?
                             1'b1 : pending_d[sb_addr_i];
      pending_d[ZERO_IDX] = 1'b0;
   end

   // Pending vector register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   // Stall when any read port needs a register whose load has not returned.
   always_comb begin
      stall_s = 1'b0;
      for (int i = 0; i < NUM_RD; i++) begin
`ifdef REGFILE_SB_BYPASS_EN
         stall_s = stall_s |
                   (pending_q[rd_addr_i[i*ADDR_W +: ADDR_W]] &
                    ~(wr_fire_i & (wr_idx_i == rd_addr_i[i*ADDR_W +: ADDR_W])));
`else
         stall_s = stall_s | pending_q[rd_addr_i[i*ADDR_W +: ADDR_W]];
`endif
      end
   end

   assign stall_o   = stall_s;
   assign pending_o = pending_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with load scoreboard and link-register write.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_RD = DEF_NUM_RD
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     link_en,
   input  logic [DATA_W-1:0]        link_data,
   input  logic                     sb_set,
   input  logic [ADDR_W-1:0]        sb_addr,
   output logic                     stall,
   output logic [(2**ADDR_W)-1:0]   pending
);

   localparam int               DEPTH    = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(link_index(ADDR_W));

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_idx_s;
   logic [DATA_W-1:0] wr_val_s;
   logic              wr_fire_s;

   // Resolve the effective write; link overrides the normal write-back port.
   always_comb begin
      if (link_en) begin
         wr_idx_s = LINK_IDX;
         wr_val_s = link_data;
      end else begin
         wr_idx_s = wr_addr;
         wr_val_s = wr_data;
      end
      wr_fire_s = (wr_en | link_en) & ~reset & (wr_idx_s != ADDR_W'(ZERO_IDX));
   end

   // Storage array; register 0 is never written and is masked on read.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int j = 0; j < DEPTH; j++) begin
            mem_q[j] <= '0;
         end
      end else if (wr_fire_s) begin
         mem_q[wr_idx_s] <= wr_val_s;
      end else begin
         mem_q[wr_idx_s] <= mem_q[wr_idx_s];
      end
   end

   // Combinational read muxes.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         if (rd_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(ZERO_IDX)) begin
            rd_data[i*DATA_W +: DATA_W] = '0;
`ifdef REGFILE_SB_BYPASS_EN
         end else if (wr_fire_s && (rd_addr[i*ADDR_W +: ADDR_W] == wr_idx_s)) begin
            rd_data[i*DATA_W +: DATA_W] = wr_val_s;
`endif
         end else begin
            rd_data[i*DATA_W +: DATA_W] = mem_q[rd_addr[i*ADDR_W +: ADDR_W]];
         end
      end
   end

   regfile_sb_scoreboard #(
      .ADDR_W (ADDR_W),
      .NUM_RD (NUM_RD)
   ) u_scoreboard (
      .clk_i     (clock),
      .rst_i     (reset),
      .sb_set_i  (sb_set),
      .sb_addr_i (sb_addr),
      .wr_fire_i (wr_fire_s),
      .wr_idx_i  (wr_idx_s),
      .rd_addr_i (rd_addr),
      .stall_o   (stall),
      .pending_o (pending)
   );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default and 4-port/8-entry builds).
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        link_en;
   logic [31:0] link_data;
   logic        sb_set;
   logic [4:0]  sb_addr;
   logic        stall;
   logic [31:0] pending;

   logic [11:0]  rd_addr_b;
   logic [127:0] rd_data_b;
   logic         wr_en_b;
   logic [2:0]   wr_addr_b;
   logic [31:0]  wr_data_b;
   logic         link_en_b;
   logic [31:0]  link_data_b;
   logic         sb_set_b;
   logic [2:0]   sb_addr_b;
   logic         stall_b;
   logic [7:0]   pending_b;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   regfile_sb dut (
      .clock (clk), .reset (reset), .rd_addr (rd_addr), .rd_data (rd_data),
      .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
      .link_en (link_en), .link_data (link_data),
      .sb_set (sb_set), .sb_addr (sb_addr), .stall (stall), .pending (pending)
   );

   regfile_sb #(.DATA_W(32), .ADDR_W(3), .NUM_RD(4)) dut_b (
      .clock (clk), .reset (reset), .rd_addr (rd_addr_b), .rd_data (rd_data_b),
      .wr_en (wr_en_b), .wr_addr (wr_addr_b), .wr_data (wr_data_b),
      .link_en (link_en_b), .link_data (link_data_b),
      .sb_set (sb_set_b), .sb_addr (sb_addr_b), .stall (stall_b), .pending (pending_b)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      link_en = 1'b0; link_data = '0; sb_set = 1'b0; sb_addr = '0;
      rd_addr_b = '0; wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
      link_en_b = 1'b0; link_data_b = '0; sb_set_b = 1'b0; sb_addr_b = '0;
      step(); step();
      reset = 1'b0;

      // Post-reset: every index reads 0, no stall, nothing pending.
      for (int k = 0; k < 32; k++) begin
         rd_addr = {5'(31 - k), 5'(k)};
         #1;
         chk("rst_rd0", rd_data[31:0], 64'h0);
         chk("rst_rd1", rd_data[63:32], 64'h0);
         chk("rst_stall", stall, 64'h0);
      end
      chk("rst_pending", pending, 64'h0);

      // Plain write to index 5.
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_addr = {5'd0, 5'd5};
      #1;
`ifdef REGFILE_SB_BYPASS_EN
      chk("wr5_same", rd_data[31:0], 64'hDEADBEEF);
`else
      chk("wr5_same", rd_data[31:0], 64'h0);
`endif
      step();
      wr_en = 1'b0;
      #1;
      chk("wr5_next", rd_data[31:0], 64'hDEADBEEF);

      // Writes to index 0 are discarded.
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
      step();
      wr_en = 1'b0; rd_addr = {5'd0, 5'd0};
      #1;
      chk("r0_zero", rd_data[31:0], 64'h0);

      // Link write overrides the normal write port.
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hAAAA5555;
      link_en = 1'b1; link_data = 32'h00400010;
      step();
      wr_en = 1'b0; link_en = 1'b0; rd_addr = {5'd7, 5'd31};
      #1;
      chk("link_r31", rd_data[31:0], 64'h00400010);
      chk("link_r7", rd_data[63:32], 64'h0);

      // Scoreboard set, stall, then clear by write-back.
      sb_set = 1'b1; sb_addr = 5'd8;
      step();
      sb_set = 1'b0; rd_addr = {5'd8, 5'd5};
      #1;
      chk("sb8_stall", stall, 64'h1);
      chk("sb8_pending", pending, 64'h0000_0100);
      wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'h55;
      #1;
`ifdef REGFILE_SB_BYPASS_EN
      chk("sb8_wr_stall", stall, 64'h0);
`else
      chk("sb8_wr_stall", stall, 64'h1);
`endif
      step();
      wr_en = 1'b0;
      #1;
      chk("sb8_clr_pending", pending, 64'h0);
      chk("sb8_clr_stall", stall, 64'h0);
      chk("sb8_rd1", rd_data[63:32], 64'h55);

      // Set and write of the same index: set wins; sb to index 0 ignored.
      sb_set = 1'b1; sb_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
      step();
      sb_addr = 5'd0; wr_en = 1'b0;
      step();
      sb_set = 1'b0; rd_addr = {5'd9, 5'd0};
      #1;
      chk("sb9_pending", pending, 64'h0000_0200);
      chk("sb9_stall", stall, 64'h1);
      chk("sb9_data", rd_data[63:32], 64'h99);

      // Reset mid-operation with a write and a pending bit.
      sb_set = 1'b1; sb_addr = 5'd4;
      step();
      sb_set = 1'b0;
      #1;
      chk("pre_rst_pending", pending, 64'h0000_0210);
      reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hFF;
      step();
      reset = 1'b0; wr_en = 1'b0; rd_addr = {5'd5, 5'd3};
      #1;
      chk("mid_rst_r3", rd_data[31:0], 64'h0);
      chk("mid_rst_r5", rd_data[63:32], 64'h0);
      chk("mid_rst_pending", pending, 64'h0);
      chk("mid_rst_stall", stall, 64'h0);

      // 4-port / 8-entry build: link lands in index 7, shared reads agree.
      link_en_b = 1'b1; link_data_b = 32'h000000A4; wr_en_b = 1'b1; wr_addr_b = 3'd2;
      wr_data_b = 32'h0BAD0BAD;
      step();
      link_en_b = 1'b0; wr_en_b = 1'b1; wr_addr_b = 3'd2; wr_data_b = 32'h13579BDF;
      step();
      wr_en_b = 1'b0; rd_addr_b = {3'd7, 3'd0, 3'd2, 3'd7};
      #1;
      chk("b_link7", rd_data_b[31:0], 64'h000000A4);
      chk("b_link7_p3", rd_data_b[127:96], 64'h000000A4);
      rd_addr_b = {3'd2, 3'd2, 3'd2, 3'd2};
      #1;
      for (int p = 0; p < 4; p++) begin
         chk("b_same_idx", rd_data_b[p*32 +: 32], 64'h13579BDF);
      end
      chk("b_stall", stall_b, 64'h0);
      chk("b_pending", pending_b, 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
